id_ex_pipe_reg: RTL and testbench

- Parametrised ID/EX pipeline register with per-stage valid, stall (hold), flush (bubble) and a saturating bubble counter.
- Replaces the fixed-width ID/EX latch between the decode stage and the EX stage.
- Captures decode control and datapath fields on each rising edge and splits the EX control bundle into individual ALU controls.
- The hazard unit drives stall and flush.

---
 rtl/id_ex_pipe_reg_if.sv | 75 +++++++
 rtl/id_ex_pipe_reg.sv | 114 +++++++++++
 tb/tb_id_ex_pipe_reg.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_pipe_reg_if.sv
// Decode-to-EX bundle for id_ex_pipe_reg, including the hazard-unit stall/flush controls.
// Optional macro ID_EX_RS_FWD_EN adds the rs specifier (ID_instr_25_21 / EX_instr_25_21).
interface id_ex_pipe_reg_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  stall;
  logic                  flush;
  logic                  ID_valid;
  logic [1:0]            ID_wb;
  logic [2:0]            ID_m;
  logic [3:0]            ID_ex;
  logic [DATA_W-1:0]     ID_pc_plus_4;
  logic [DATA_W-1:0]     ID_reg_data1;
  logic [DATA_W-1:0]     ID_reg_data2;
  logic [DATA_W-1:0]     ID_sign_ext_imm;
  logic [REG_ADDR_W-1:0] ID_instr_20_16;
  logic [REG_ADDR_W-1:0] ID_instr_15_11;

  logic                  EX_valid;
  logic [1:0]            EX_wb;
  logic [2:0]            EX_m;
  logic                  EX_reg_dst;
  logic [1:0]            EX_alu_op;
  logic                  EX_alu_src;
  logic [DATA_W-1:0]     EX_pc_plus_4;
  logic [DATA_W-1:0]     EX_reg_data1;
  logic [DATA_W-1:0]     EX_reg_data2;
  logic [DATA_W-1:0]     EX_sign_ext_imm;
  logic [REG_ADDR_W-1:0] EX_instr_20_16;
  logic [REG_ADDR_W-1:0] EX_instr_15_11;
  logic [CNT_W-1:0]      bubble_count;

`ifdef ID_EX_RS_FWD_EN
  logic [REG_ADDR_W-1:0] ID_instr_25_21;
  logic [REG_ADDR_W-1:0] EX_instr_25_21;

  modport master (
    output stall, flush, ID_valid, ID_wb, ID_m, ID_ex,
           ID_pc_plus_4, ID_reg_data1, ID_reg_data2, ID_sign_ext_imm,
           ID_instr_20_16, ID_instr_15_11, ID_instr_25_21,
    input  EX_valid, EX_wb, EX_m, EX_reg_dst, EX_alu_op, EX_alu_src,
           EX_pc_plus_4, EX_reg_data1, EX_reg_data2, EX_sign_ext_imm,
           EX_instr_20_16, EX_instr_15_11, EX_instr_25_21, bubble_count
  );

  modport slave (
    input  stall, flush, ID_valid, ID_wb, ID_m, ID_ex,
           ID_pc_plus_4, ID_reg_data1, ID_reg_data2, ID_sign_ext_imm,
           ID_instr_20_16, ID_instr_15_11, ID_instr_25_21,
    output EX_valid, EX_wb, EX_m, EX_reg_dst, EX_alu_op, EX_alu_src,
           EX_pc_plus_4, EX_reg_data1, EX_reg_data2, EX_sign_ext_imm,
           EX_instr_20_16, EX_instr_15_11, EX_instr_25_21, bubble_count
  );
`else
  modport master (
    output stall, flush, ID_valid, ID_wb, ID_m, ID_ex,
           ID_pc_plus_4, ID_reg_data1, ID_reg_data2, ID_sign_ext_imm,
           ID_instr_20_16, ID_instr_15_11,
    input  EX_valid, EX_wb, EX_m, EX_reg_dst, EX_alu_op, EX_alu_src,
           EX_pc_plus_4, EX_reg_data1, EX_reg_data2, EX_sign_ext_imm,
           EX_instr_20_16, EX_instr_15_11, bubble_count
  );

  modport slave (
    input  stall, flush, ID_valid, ID_wb, ID_m, ID_ex,
           ID_pc_plus_4, ID_reg_data1, ID_reg_data2, ID_sign_ext_imm,
           ID_instr_20_16, ID_instr_15_11,
    output EX_valid, EX_wb, EX_m, EX_reg_dst, EX_alu_op, EX_alu_src,
           EX_pc_plus_4, EX_reg_data1, EX_reg_data2, EX_sign_ext_imm,
           EX_instr_20_16, EX_instr_15_11, bubble_count
  );
`endif
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid, stall (hold), flush (bubble) and a saturating bubble counter.
// Optional macro ID_EX_RS_FWD_EN registers the rs specifier for the forwarding unit.
module id_ex_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             startin,
  id_ex_pipe_reg_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                  valid_q;
  logic [1:0]            wb_q;
  logic [2:0]            m_q;
  logic [3:0]            ex_q;
  logic [DATA_W-1:0]     pc_plus_4_q;
  logic [DATA_W-1:0]     reg_data1_q;
  logic [DATA_W-1:0]     reg_data2_q;
  logic [DATA_W-1:0]     sign_ext_imm_q;
  logic [REG_ADDR_W-1:0] rt_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [CNT_W-1:0]      bubble_cnt_q;
  logic [CNT_W-1:0]      bubble_cnt_inc;
`ifdef ID_EX_RS_FWD_EN
  logic [REG_ADDR_W-1:0] rs_q;
`endif

  assign bubble_cnt_inc = (bubble_cnt_q == CNT_MAX) ? bubble_cnt_q
                                                     : bubble_cnt_q + CNT_W'(1);

  // Control half: an invalid slot loads zero controls so downstream never sees a write from a bubble.
  always_ff @(posedge clk or posedge startin) begin
    if (startin) begin
      valid_q      <= 1'b0;
      wb_q         <= '0;
      m_q          <= '0;
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else if (bus.flush) begin
      valid_q      <= 1'b0;
      wb_q         <= '0;
      m_q          <= '0;
      ex_q         <= '0;
      bubble_cnt_q <= bubble_cnt_inc;
    end else if (!bus.stall) begin
      valid_q <= bus.ID_valid;
      if (bus.ID_valid) begin
        wb_q <= bus.ID_wb;
        m_q  <= bus.ID_m;
        ex_q <= bus.ID_ex;
      end else begin
        wb_q         <= '0;
        m_q          <= '0;
        ex_q         <= '0;
        bubble_cnt_q <= bubble_cnt_inc;
      end
    end
  end

  // Datapath half: captured regardless of ID_valid, zeroed only by flush or reset.
  always_ff @(posedge clk or posedge startin) begin
    if (startin) begin
      pc_plus_4_q    <= '0;
      reg_data1_q    <= '0;
      reg_data2_q    <= '0;
      sign_ext_imm_q <= '0;
      rt_q           <= '0;
      rd_q           <= '0;
`ifdef ID_EX_RS_FWD_EN
      rs_q           <= '0;
`endif
    end else if (bus.flush) begin
      pc_plus_4_q    <= '0;
      reg_data1_q    <= '0;
      reg_data2_q    <= '0;
      sign_ext_imm_q <= '0;
      rt_q           <= '0;
      rd_q           <= '0;
`ifdef ID_EX_RS_FWD_EN
      rs_q           <= '0;
`endif
    end else if (!bus.stall) begin
      pc_plus_4_q    <= bus.ID_pc_plus_4;
      reg_data1_q    <= bus.ID_reg_data1;
      reg_data2_q    <= bus.ID_reg_data2;
      sign_ext_imm_q <= bus.ID_sign_ext_imm;
      rt_q           <= bus.ID_instr_20_16;
      rd_q           <= bus.ID_instr_15_11;
`ifdef ID_EX_RS_FWD_EN
      rs_q           <= bus.ID_instr_25_21;
`endif
    end
  end

  assign bus.EX_valid        = valid_q;
  assign bus.EX_wb           = wb_q;
  assign bus.EX_m            = m_q;
  assign bus.EX_reg_dst      = ex_q[3];
  assign bus.EX_alu_op       = ex_q[2:1];
  assign bus.EX_alu_src      = ex_q[0];
  assign bus.EX_pc_plus_4    = pc_plus_4_q;
  assign bus.EX_reg_data1    = reg_data1_q;
  assign bus.EX_reg_data2    = reg_data2_q;
  assign bus.EX_sign_ext_imm = sign_ext_imm_q;
  assign bus.EX_instr_20_16  = rt_q;
  assign bus.EX_instr_15_11  = rd_q;
  assign bus.bubble_count    = bubble_cnt_q;
`ifdef ID_EX_RS_FWD_EN
  assign bus.EX_instr_25_21  = rs_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed vector table, reset/saturation sequences, random run vs model.
// Honours ID_EX_RS_FWD_EN when the design is built with it.
module tb_id_ex_pipe_reg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 16;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        stall, flush, valid;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rt, rd, rs;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rt, rd, rs;
    logic [15:0] cnt;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic startin;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs [10];
  out_t model;

  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) bus ();
  id_ex_pipe_reg_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(2))     sat_bus ();

  id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .startin(startin), .bus(bus)
  );

  id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(2)) dut_sat (
    .clk(clk), .startin(startin), .bus(sat_bus)
  );

  function automatic in_t mk_in(logic st, logic fl, logic v, logic [1:0] wb, logic [2:0] m,
                                logic [3:0] ex, logic [31:0] pc, logic [31:0] d1, logic [31:0] d2,
                                logic [31:0] imm, logic [4:0] rt, logic [4:0] rd, logic [4:0] rs);
    in_t s;
    s.stall = st; s.flush = fl; s.valid = v; s.wb = wb; s.m = m; s.ex = ex;
    s.pc = pc; s.d1 = d1; s.d2 = d2; s.imm = imm; s.rt = rt; s.rd = rd; s.rs = rs;
    return s;
  endfunction

  function automatic out_t mk_out(logic v, logic [1:0] wb, logic [2:0] m, logic [3:0] ex,
                                  logic [31:0] pc, logic [31:0] d1, logic [31:0] d2, logic [31:0] imm,
                                  logic [4:0] rt, logic [4:0] rd, logic [4:0] rs, logic [15:0] cnt);
    out_t o;
    o.valid = v; o.wb = wb; o.m = m; o.ex = ex; o.pc = pc; o.d1 = d1; o.d2 = d2;
    o.imm = imm; o.rt = rt; o.rd = rd; o.rs = rs; o.cnt = cnt;
    return o;
  endfunction

  // Reference behaviour: one rising edge applied to the architectural state of the EX slot.
  function automatic out_t model_step(in_t s, out_t cur);
    out_t nx;
    int   bumped;
    nx     = cur;
    bumped = int'(cur.cnt) + 1;
    if (bumped > CNT_MAX) bumped = CNT_MAX;
    if (s.flush) begin
      nx     = '0;
      nx.cnt = 16'(bumped);
    end else if (!s.stall) begin
      nx.pc  = s.pc;  nx.d1 = s.d1; nx.d2 = s.d2; nx.imm = s.imm;
      nx.rt  = s.rt;  nx.rd = s.rd; nx.rs = s.rs;
      nx.valid = s.valid;
      nx.wb  = s.valid ? s.wb : 2'b00;
      nx.m   = s.valid ? s.m  : 3'b000;
      nx.ex  = s.valid ? s.ex : 4'b0000;
      if (!s.valid) nx.cnt = 16'(bumped);
    end
    return nx;
  endfunction

  task automatic applyStimulus(input in_t s);
    bus.stall           = s.stall;
    bus.flush           = s.flush;
    bus.ID_valid        = s.valid;
    bus.ID_wb           = s.wb;
    bus.ID_m            = s.m;
    bus.ID_ex           = s.ex;
    bus.ID_pc_plus_4    = s.pc;
    bus.ID_reg_data1    = s.d1;
    bus.ID_reg_data2    = s.d2;
    bus.ID_sign_ext_imm = s.imm;
    bus.ID_instr_20_16  = s.rt;
    bus.ID_instr_15_11  = s.rd;
`ifdef ID_EX_RS_FWD_EN
    bus.ID_instr_25_21  = s.rs;
`endif
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input out_t e);
    checkOutput({tag, " EX_valid"},        64'(bus.EX_valid),        64'(e.valid));
    checkOutput({tag, " EX_wb"},           64'(bus.EX_wb),           64'(e.wb));
    checkOutput({tag, " EX_m"},            64'(bus.EX_m),            64'(e.m));
    checkOutput({tag, " EX_reg_dst"},      64'(bus.EX_reg_dst),      64'(e.ex[3]));
    checkOutput({tag, " EX_alu_op"},       64'(bus.EX_alu_op),       64'(e.ex[2:1]));
    checkOutput({tag, " EX_alu_src"},      64'(bus.EX_alu_src),      64'(e.ex[0]));
    checkOutput({tag, " EX_pc_plus_4"},    64'(bus.EX_pc_plus_4),    64'(e.pc));
    checkOutput({tag, " EX_reg_data1"},    64'(bus.EX_reg_data1),    64'(e.d1));
    checkOutput({tag, " EX_reg_data2"},    64'(bus.EX_reg_data2),    64'(e.d2));
    checkOutput({tag, " EX_sign_ext_imm"}, 64'(bus.EX_sign_ext_imm), 64'(e.imm));
    checkOutput({tag, " EX_instr_20_16"},  64'(bus.EX_instr_20_16),  64'(e.rt));
    checkOutput({tag, " EX_instr_15_11"},  64'(bus.EX_instr_15_11),  64'(e.rd));
    checkOutput({tag, " bubble_count"},    64'(bus.bubble_count),    64'(e.cnt));
`ifdef ID_EX_RS_FWD_EN
    checkOutput({tag, " EX_instr_25_21"},  64'(bus.EX_instr_25_21),  64'(e.rs));
`endif
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetBoth();
    startin = 1'b1;
    stepCycle();
    stepCycle();
    startin = 1'b0;
  endtask

  initial begin
    in_t s;
    out_t zero_o;
    zero_o = '0;
    startin = 1'b1;
    applyStimulus('0);
    sat_bus.stall = 1'b0; sat_bus.flush = 1'b0; sat_bus.ID_valid = 1'b1;
    sat_bus.ID_wb = '0; sat_bus.ID_m = '0; sat_bus.ID_ex = '0;
    sat_bus.ID_pc_plus_4 = '0; sat_bus.ID_reg_data1 = '0; sat_bus.ID_reg_data2 = '0;
    sat_bus.ID_sign_ext_imm = '0; sat_bus.ID_instr_20_16 = '0; sat_bus.ID_instr_15_11 = '0;
`ifdef ID_EX_RS_FWD_EN
    sat_bus.ID_instr_25_21 = '0;
`endif

    vecs[0] = '{mk_in(0,0,1,2'b10,3'b101,4'b1101,32'h4,32'h12345678,32'h0,32'h10,5'b10101,5'd3,5'b11011),
                mk_out(1,2'b10,3'b101,4'b1101,32'h4,32'h12345678,32'h0,32'h10,5'b10101,5'd3,5'b11011,16'd0)};
    for (int k = 1; k <= 3; k++)
      vecs[k] = '{mk_in(1,0,1,2'b01,3'b010,4'b0010,32'h8,32'h11111111,32'hCAFEBABE,32'h20,5'd1,5'd2,5'd4),
                  vecs[0].o};
    vecs[4] = '{mk_in(0,0,1,2'b10,3'b101,4'b1101,32'h8,32'h12345678,32'hCAFEBABE,32'h20,5'b10101,5'd3,5'b11011),
                mk_out(1,2'b10,3'b101,4'b1101,32'h8,32'h12345678,32'hCAFEBABE,32'h20,5'b10101,5'd3,5'b11011,16'd0)};
    vecs[5] = '{mk_in(1,1,1,2'b11,3'b111,4'b1111,32'hC,32'hFFFFFFFF,32'hFFFFFFFF,32'hFFFFFFFF,5'd31,5'd31,5'd31),
                mk_out(0,2'b00,3'b000,4'b0000,32'h0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,16'd1)};
    vecs[6] = '{mk_in(0,0,0,2'b11,3'b111,4'b1111,32'h10,32'hDEADBEEF,32'h1,32'h2,5'd7,5'd8,5'd9),
                mk_out(0,2'b00,3'b000,4'b0000,32'h10,32'hDEADBEEF,32'h1,32'h2,5'd7,5'd8,5'd9,16'd2)};
    vecs[7] = '{mk_in(0,0,1,2'b01,3'b010,4'b0110,32'h14,32'hA5A5A5A5,32'h5A5A5A5A,32'h3,5'd10,5'd11,5'd12),
                mk_out(1,2'b01,3'b010,4'b0110,32'h14,32'hA5A5A5A5,32'h5A5A5A5A,32'h3,5'd10,5'd11,5'd12,16'd2)};
    vecs[8] = '{mk_in(1,0,0,2'b11,3'b111,4'b1111,32'h99,32'h0,32'h0,32'h0,5'd1,5'd1,5'd1), vecs[7].o};
    vecs[9] = '{mk_in(0,1,1,2'b11,3'b111,4'b1111,32'h18,32'h1,32'h2,32'h3,5'd4,5'd5,5'd6),
                mk_out(0,2'b00,3'b000,4'b0000,32'h0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,16'd3)};

    stepCycle();
    checkAll("reset", zero_o);
    startin = 1'b0;

    for (int k = 0; k < 10; k++) begin
      applyStimulus(vecs[k].i);
      stepCycle();
      checkAll($sformatf("vec%0d", k), vecs[k].o);
    end

    // Asynchronous clear mid-cycle, held across an edge, then a normal first update.
    applyStimulus(vecs[0].i);
    stepCycle();
    #3 startin = 1'b1;
    #1 checkAll("async_clear", zero_o);
    applyStimulus(vecs[5].i);
    stepCycle();
    checkAll("clear_held", zero_o);
    #3 startin = 1'b0;
    applyStimulus(vecs[7].i);
    stepCycle();
    checkAll("post_reset_load", mk_out(1,2'b01,3'b010,4'b0110,32'h14,32'hA5A5A5A5,32'h5A5A5A5A,
                                       32'h3,5'd10,5'd11,5'd12,16'd0));

    // Two-bit counter: 1, 2, 3, then stuck at 3, including a non-flush bubble.
    resetBoth();
    sat_bus.flush = 1'b1;
    for (int k = 0; k < 5; k++) begin
      stepCycle();
      checkOutput($sformatf("sat flush%0d", k), 64'(sat_bus.bubble_count), 64'((k < 3) ? k + 1 : 3));
    end
    sat_bus.flush = 1'b0;
    sat_bus.ID_valid = 1'b0;
    stepCycle();
    checkOutput("sat invalid", 64'(sat_bus.bubble_count), 64'(3));
    checkOutput("sat EX_valid", 64'(sat_bus.EX_valid), 64'(0));

    // Random run against the reference model.
    resetBoth();
    model = '0;
    for (int n = 0; n < 400; n++) begin
      s = mk_in(($urandom_range(3) == 0), ($urandom_range(9) == 0), ($urandom_range(9) < 7),
                2'($urandom), 3'($urandom), 4'($urandom), $urandom, $urandom, $urandom, $urandom,
                5'($urandom), 5'($urandom), 5'($urandom));
      applyStimulus(s);
      stepCycle();
      model = model_step(s, model);
      checkAll($sformatf("rand%0d", n), model);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
